// File: rtl/decode_stage.sv
// Decode stage: registers fetched words, assembles 16/32-bit instructions, splits fields and
// issues relative-branch requests to fetch. Optional macro DECODE_ILLEGAL_EN adds dec_illegal.
module decode_stage #(
    parameter int PC_WIDTH   = 20,
    parameter int INSN_WIDTH = 16,
    parameter int REG_BITS   = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INSN_WIDTH-1:0] fetchoutput,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    input  logic                  fetch_valid,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  hold_fetch,
    output logic                  dec_valid,
    output logic [PC_WIDTH-1:0]   dec_pc,
    output logic                  dec_is32,
    output logic [1:0]            dec_class,
    output logic [7:0]            dec_opcode,
    output logic [REG_BITS-1:0]   dec_rd,
    output logic [REG_BITS-1:0]   dec_ra,
    output logic [REG_BITS-1:0]   dec_rb,
    output logic [11:0]           dec_imm,
    output logic [2:0]            pcjumpenable,
    output logic [8:0]            pcchange,
    output logic [2:0]            pclocation
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic                  dec_illegal
`endif
);

    typedef enum logic [1:0] {FIRST = 2'd0, SECOND = 2'd1, SHADOW = 2'd2} state_e;

    typedef struct packed {
        logic                valid;
        logic [PC_WIDTH-1:0] pc;
        logic                is32;
        logic [1:0]          cls;
        logic [7:0]          opc;
        logic [REG_BITS-1:0] rd;
        logic [REG_BITS-1:0] ra;
        logic [REG_BITS-1:0] rb;
        logic [11:0]         imm;
        logic [2:0]          jmp;
        logic [8:0]          chg;
    } dec_t;

    state_e                state_q, state_d;
    logic [INSN_WIDTH-1:0] w1_q, w1_d;
    logic [PC_WIDTH-1:0]   pc1_q, pc1_d;
    dec_t                  out_q, out_d;
    logic [INSN_WIDTH-1:0] w;
`ifdef DECODE_ILLEGAL_EN
    logic                  ill_q, ill_d;
`endif

    assign w = fetchoutput;

    always_comb begin
        state_d = state_q;
        w1_d    = w1_q;
        pc1_d   = pc1_q;
        out_d   = out_q;
`ifdef DECODE_ILLEGAL_EN
        ill_d   = ill_q;
`endif
        if (flush) begin
            state_d     = FIRST;
            w1_d        = '0;
            pc1_d       = '0;
            out_d.valid = 1'b0;
            out_d.jmp   = 3'd0;
`ifdef DECODE_ILLEGAL_EN
            ill_d       = 1'b0;
`endif
        end else if (!stall) begin
            // Pulses last one accepted-or-idle cycle; decoded fields hold otherwise.
            out_d.valid = 1'b0;
            out_d.jmp   = 3'd0;
`ifdef DECODE_ILLEGAL_EN
            ill_d       = 1'b0;
`endif
            if (fetch_valid) begin
                case (state_q)
                    FIRST: begin
                        if (w[15]) begin
                            w1_d    = w;
                            pc1_d   = fetch_pc;
                            state_d = SECOND;
                        end else begin
                            out_d.valid = 1'b1;
                            out_d.pc    = fetch_pc;
                            out_d.is32  = 1'b0;
                            out_d.cls   = w[14:13];
                            out_d.opc   = {4'b0, w[12:9]};
                            out_d.rd    = REG_BITS'(w[8:6]);
                            out_d.ra    = REG_BITS'(w[5:3]);
                            out_d.rb    = REG_BITS'(w[2:0]);
                            out_d.imm   = {6'b0, w[5:0]};
                            if (w[14:13] == 2'b11 && w[12:9] == 4'b0000) begin
                                out_d.jmp = 3'd1;
                                out_d.chg = w[8:0];
                                state_d   = SHADOW;
                            end
                        end
                    end
                    SECOND: begin
                        state_d = FIRST;
`ifdef DECODE_ILLEGAL_EN
                        if (!w[15]) begin
                            ill_d = 1'b1;
                        end else
`endif
                        begin
                            out_d.valid = 1'b1;
                            out_d.pc    = pc1_q;
                            out_d.is32  = 1'b1;
                            out_d.cls   = w1_q[14:13];
                            out_d.opc   = {w[12:9], w1_q[12:9]};
                            out_d.rd    = REG_BITS'({w[8:6], w1_q[8:6]});
                            out_d.ra    = REG_BITS'({w[5:3], w1_q[5:3]});
                            out_d.rb    = REG_BITS'({w[2:0], w1_q[2:0]});
                            out_d.imm   = {w[5:0], w1_q[5:0]};
                        end
                    end
                    SHADOW: state_d = FIRST;  // word fetched behind the branch is dropped
                    default: state_d = FIRST;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FIRST;
            w1_q    <= '0;
            pc1_q   <= '0;
            out_q   <= '0;
`ifdef DECODE_ILLEGAL_EN
            ill_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            w1_q    <= w1_d;
            pc1_q   <= pc1_d;
            out_q   <= out_d;
`ifdef DECODE_ILLEGAL_EN
            ill_q   <= ill_d;
`endif
        end
    end

    assign hold_fetch   = stall;
    assign dec_valid    = out_q.valid;
    assign dec_pc       = out_q.pc;
    assign dec_is32     = out_q.is32;
    assign dec_class    = out_q.cls;
    assign dec_opcode   = out_q.opc;
    assign dec_rd       = out_q.rd;
    assign dec_ra       = out_q.ra;
    assign dec_rb       = out_q.rb;
    assign dec_imm      = out_q.imm;
    assign pcjumpenable = out_q.jmp;
    assign pcchange     = out_q.chg;
    assign pclocation   = 3'd0;
`ifdef DECODE_ILLEGAL_EN
    assign dec_illegal  = ill_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed plus random bench for decode_stage against an arithmetic reference model.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset, fetch_valid, stall, flush;
    logic [15:0] fetchoutput;
    logic [19:0] fetch_pc;
    logic        hold_fetch, dec_valid, dec_is32;
    logic [19:0] dec_pc;
    logic [1:0]  dec_class;
    logic [7:0]  dec_opcode;
    logic [5:0]  dec_rd, dec_ra, dec_rb;
    logic [11:0] dec_imm;
    logic [2:0]  pcjumpenable, pclocation;
    logic [8:0]  pcchange;
`ifdef DECODE_ILLEGAL_EN
    logic        dec_illegal;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: expected outputs plus "half instruction pending" and "drop next word".
    int e_valid, e_pc, e_is32, e_cls, e_opc, e_rd, e_ra, e_rb, e_imm, e_jmp, e_chg, e_ill;
    int m_pending, m_w1, m_pc1, m_drop;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock(clock), .reset(reset), .fetchoutput(fetchoutput), .fetch_pc(fetch_pc),
        .fetch_valid(fetch_valid), .stall(stall), .flush(flush), .hold_fetch(hold_fetch),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_is32(dec_is32), .dec_class(dec_class),
        .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_ra(dec_ra), .dec_rb(dec_rb),
        .dec_imm(dec_imm), .pcjumpenable(pcjumpenable), .pcchange(pcchange),
        .pclocation(pclocation)
`ifdef DECODE_ILLEGAL_EN
        , .dec_illegal(dec_illegal)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input int r, input int fv, input int w, input int pc, input int st,
                         input int fl);
        if (r != 0) begin
            {e_valid, e_pc, e_is32, e_cls, e_opc, e_rd, e_ra, e_rb, e_imm} = '0;
            {e_jmp, e_chg, e_ill, m_pending, m_w1, m_pc1, m_drop} = '0;
        end else if (fl != 0) begin
            e_valid = 0; e_jmp = 0; e_ill = 0; m_pending = 0; m_drop = 0;
        end else if (st == 0) begin
            e_valid = 0; e_jmp = 0; e_ill = 0;
            if (fv != 0) begin
                if (m_drop != 0) begin
                    m_drop = 0;
                end else if (m_pending != 0) begin
                    m_pending = 0;
`ifdef DECODE_ILLEGAL_EN
                    if (w < 32768) e_ill = 1;
                    else begin
`else
                    begin
`endif
                        e_valid = 1; e_is32 = 1; e_pc = m_pc1;
                        e_cls = (m_w1 / 8192) % 4;
                        e_opc = ((w / 512) % 16) * 16 + (m_w1 / 512) % 16;
                        e_rd  = ((w / 64) % 8) * 8 + (m_w1 / 64) % 8;
                        e_ra  = ((w / 8) % 8) * 8 + (m_w1 / 8) % 8;
                        e_rb  = (w % 8) * 8 + m_w1 % 8;
                        e_imm = (w % 64) * 64 + m_w1 % 64;
                    end
                end else if (w >= 32768) begin
                    m_pending = 1; m_w1 = w; m_pc1 = pc;
                end else begin
                    e_valid = 1; e_is32 = 0; e_pc = pc;
                    e_cls = (w / 8192) % 4;
                    e_opc = (w / 512) % 16;
                    e_rd  = (w / 64) % 8;
                    e_ra  = (w / 8) % 8;
                    e_rb  = w % 8;
                    e_imm = w % 64;
                    if (e_cls == 3 && e_opc == 0) begin
                        e_jmp = 1; e_chg = w % 512; m_drop = 1;
                    end
                end
            end
        end
    endtask

    // Drive one cycle, let it clock, then compare against the model.
    task automatic step(input int r, input int fv, input int w, input int pc, input int st,
                        input int fl);
        reset = 1'(r); fetch_valid = 1'(fv); fetchoutput = 16'(w); fetch_pc = 20'(pc);
        stall = 1'(st); flush = 1'(fl);
        #1;
        chk("hold_fetch", int'(hold_fetch), st);
        @(posedge clock);
        model(r, fv, w, pc, st, fl);
        #1;
        chk("dec_valid", int'(dec_valid), e_valid);
        chk("pcjumpenable", int'(pcjumpenable), e_jmp);
        chk("pclocation", int'(pclocation), 0);
`ifdef DECODE_ILLEGAL_EN
        chk("dec_illegal", int'(dec_illegal), e_ill);
`endif
        if (e_valid != 0) begin
            chk("dec_pc", int'(dec_pc), e_pc);
            chk("dec_is32", int'(dec_is32), e_is32);
            chk("dec_class", int'(dec_class), e_cls);
            chk("dec_opcode", int'(dec_opcode), e_opc);
            chk("dec_rd", int'(dec_rd), e_rd);
            chk("dec_ra", int'(dec_ra), e_ra);
            chk("dec_rb", int'(dec_rb), e_rb);
            chk("dec_imm", int'(dec_imm), e_imm);
        end
        if (e_jmp != 0) chk("pcchange", int'(pcchange), e_chg);
    endtask

    initial begin
        // reset: every output zero
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 'h0A5B, 3, 0, 0);
        chk("rst_pc", int'(dec_pc), 0);
        chk("rst_opcode", int'(dec_opcode), 0);
        chk("rst_imm", int'(dec_imm), 0);
        chk("rst_chg", int'(pcchange), 0);
        chk("rst_is32", int'(dec_is32), 0);

        // 16-bit decode with literal expectations
        step(0, 1, 'h0A5B, 5, 0, 0);
        chk("t1_valid", int'(dec_valid), 1);
        chk("t1_pc", int'(dec_pc), 5);
        chk("t1_opcode", int'(dec_opcode), 'h05);
        chk("t1_rd", int'(dec_rd), 1);
        chk("t1_ra", int'(dec_ra), 3);
        chk("t1_rb", int'(dec_rb), 3);
        step(0, 0, 0, 0, 0, 0);

        // 32-bit pair
        step(0, 1, 'h8A5B, 8, 0, 0);
        chk("t2_first_invalid", int'(dec_valid), 0);
        step(0, 1, 'h8249, 9, 0, 0);
        chk("t2_is32", int'(dec_is32), 1);
        chk("t2_pc", int'(dec_pc), 8);
        chk("t2_opcode", int'(dec_opcode), 'h15);

        // branch, shadow dropped, then a normal word
        step(0, 1, 'h6010, 'h20, 0, 0);
        chk("t3_jmp", int'(pcjumpenable), 1);
        chk("t3_chg", int'(pcchange), 'h010);
        step(0, 1, 'h0A5B, 'h21, 0, 0);
        step(0, 1, 'h0A5B, 'h30, 0, 0);

        // branch pulse held under stall
        step(0, 1, 'h61FF, 'h40, 0, 0);
        step(0, 1, 'h0123, 'h41, 1, 0);
        step(0, 1, 'h0123, 'h41, 1, 0);
        step(0, 1, 'h0123, 'h41, 0, 0);
        step(0, 1, 'h0456, 'h42, 0, 0);

        // stall three cycles mid-pair
        step(0, 1, 'h8A5B, 'h50, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 'h8249, 'h51, 1, 0);
        step(0, 1, 'h8249, 'h51, 0, 0);

        // flush mid-pair, with a branch word and a stall alongside
        step(0, 1, 'h8A5B, 'h60, 0, 0);
        step(0, 1, 'h6010, 'h61, 1, 1);
        step(0, 1, 'h0A5B, 'h62, 0, 0);
        chk("t5_is32", int'(dec_is32), 0);
        step(0, 1, 'h6010, 'h63, 0, 1);

        // second word with bit 15 clear
        step(0, 1, 'h8A5B, 'h70, 0, 0);
        step(0, 1, 'h0249, 'h71, 0, 0);
        step(0, 1, 'h0A5B, 'h72, 0, 0);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            int w;
            w = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) == 0) w = 'h6000 + int'($urandom_range(0, 511));
            step(($urandom_range(0, 63) == 0) ? 1 : 0, ($urandom_range(0, 3) != 0) ? 1 : 0,
                 w, int'($urandom_range(0, 'hFFFFF)), ($urandom_range(0, 5) == 0) ? 1 : 0,
                 ($urandom_range(0, 15) == 0) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
